// File: rtl/adder_pio_responder.sv
// Fabric-side responder for the HPS adder PIO channel: detects operand changes and
// returns the sum via a chunk-serial ripple adder. Define ADDER_PIO_SAT_EN for unsigned saturation.
module adder_pio_responder #(
    parameter int DATA_W  = 64,
    parameter int CHUNK_W = 16,
    parameter int CNT_W   = 16
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic [DATA_W-1:0] adder_a,
    input  logic [DATA_W-1:0] adder_b,
    output logic [DATA_W-1:0] adder_sum,
    output logic              carry_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [CNT_W-1:0]  op_count_o
);
    // state | meaning
    // IDLE  | watching registered operands for a change against the last accepted pair
    // ADD   | adding one CHUNK_W slice per cycle, LSB slice first

    localparam int N     = DATA_W / CHUNK_W;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_ADD  = 1'b1;

    generate
        if (DATA_W % CHUNK_W != 0) begin : g_bad_chunk
            $error("adder_pio_responder: DATA_W must be a multiple of CHUNK_W");
        end
    endgenerate

    logic [0:0]        state;
    logic [DATA_W-1:0] a_q, b_q;
    logic [DATA_W-1:0] a_last, b_last;
    logic [DATA_W-1:0] op_a, op_b;
    logic [DATA_W-1:0] acc;
    logic [IDX_W-1:0]  idx;
    logic              cy;
    logic [CHUNK_W:0]  chunk_sum;
    logic [DATA_W-1:0] acc_next;

    assign chunk_sum = {1'b0, op_a[CHUNK_W-1:0]} + {1'b0, op_b[CHUNK_W-1:0]}
                     + {{CHUNK_W{1'b0}}, cy};

    // Accumulator fills from the top so that after N slices it holds the full sum in order.
    generate
        if (N == 1) begin : g_single
            assign acc_next = chunk_sum[CHUNK_W-1:0];
        end else begin : g_multi
            assign acc_next = {chunk_sum[CHUNK_W-1:0], acc[DATA_W-1:CHUNK_W]};
        end
    endgenerate

    assign busy_o = (state == ST_ADD);

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state      <= ST_IDLE;
            a_q        <= '0;
            b_q        <= '0;
            a_last     <= '0;
            b_last     <= '0;
            op_a       <= '0;
            op_b       <= '0;
            acc        <= '0;
            idx        <= '0;
            cy         <= 1'b0;
            adder_sum  <= '0;
            carry_o    <= 1'b0;
            done_o     <= 1'b0;
            op_count_o <= '0;
        end else begin
            a_q    <= adder_a;
            b_q    <= adder_b;
            done_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if ({a_q, b_q} != {a_last, b_last}) begin
                        a_last <= a_q;
                        b_last <= b_q;
                        op_a   <= a_q;
                        op_b   <= b_q;
                        idx    <= '0;
                        cy     <= 1'b0;
                        state  <= ST_ADD;
                    end
                end
                ST_ADD: begin
                    op_a <= op_a >> CHUNK_W;
                    op_b <= op_b >> CHUNK_W;
                    acc  <= acc_next;
                    cy   <= chunk_sum[CHUNK_W];
                    idx  <= idx + IDX_W'(1);
                    if (idx == IDX_W'(N - 1)) begin
`ifdef ADDER_PIO_SAT_EN
                        adder_sum <= chunk_sum[CHUNK_W] ? {DATA_W{1'b1}} : acc_next;
`else
                        adder_sum <= acc_next;
`endif
                        carry_o    <= chunk_sum[CHUNK_W];
                        done_o     <= 1'b1;
                        op_count_o <= op_count_o + CNT_W'(1);
                        state      <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule
